// File: rtl/grf.sv
// MIPS general register file: 31 stored registers ($0 hardwired to zero), two combinational
// read ports with same-cycle write bypass, one synchronous write port, and a write-trace port.
module grf #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       A1,
    input  logic [4:0]       A2,
    input  logic [4:0]       A3,
    input  logic [31:0]      WD,
    input  logic [31:0]      PC,
    output logic [31:0]      RD1,
    output logic [31:0]      RD2,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_addr,
    output logic [31:0]      trace_data,
    output logic [CNT_W-1:0] wr_count
);

    logic [31:0]      regs_q [1:31];
    logic [31:0]      regs_d [1:31];
    logic             trace_valid_q, trace_valid_d;
    logic [31:0]      trace_pc_q, trace_pc_d;
    logic [4:0]       trace_addr_q, trace_addr_d;
    logic [31:0]      trace_data_q, trace_data_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;
    logic             commit;

    // Gating on reset keeps the bypass off while the array is held clear.
    assign commit = reset && RegWrite && (A3 != 5'd0);

    always_comb begin
        regs_d        = regs_q;
        trace_valid_d = commit;
        trace_pc_d    = trace_pc_q;
        trace_addr_d  = trace_addr_q;
        trace_data_d  = trace_data_q;
        wr_count_d    = wr_count_q;
        if (commit) begin
            regs_d[A3]   = WD;
            trace_pc_d   = PC;
            trace_addr_d = A3;
            trace_data_d = WD;
            wr_count_d   = wr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_addr_q  <= '0;
            trace_data_q  <= '0;
            wr_count_q    <= '0;
        end else begin
            regs_q        <= regs_d;
            trace_valid_q <= trace_valid_d;
            trace_pc_q    <= trace_pc_d;
            trace_addr_q  <= trace_addr_d;
            trace_data_q  <= trace_data_d;
            wr_count_q    <= wr_count_d;
        end
    end

    // Address 0 falls through every match below and reads zero.
    always_comb begin
        RD1 = '0;
        RD2 = '0;
        for (int i = 1; i < 32; i++) begin
            if (A1 == 5'(i)) RD1 = regs_q[i];
            if (A2 == 5'(i)) RD2 = regs_q[i];
        end
        if (commit && (A1 == A3) && (A1 != 5'd0)) RD1 = WD;
        if (commit && (A2 == A3) && (A2 != 5'd0)) RD2 = WD;
    end

    assign trace_valid = trace_valid_q;
    assign trace_pc    = trace_pc_q;
    assign trace_addr  = trace_addr_q;
    assign trace_data  = trace_data_q;
    assign wr_count    = wr_count_q;

endmodule

// File: doc/grf.md
# grf

General register file for the single-cycle MIPS datapath: 32 × 32-bit registers, two combinational read ports, one synchronous write port. It sits directly downstream of the destination-register select mux, which supplies the write address, and the write-back data mux, which supplies the write data. Its read ports feed the ALU operand path and store data. A registered write-trace port and a write counter support bench checking against the instruction-level reference model.

## Interface
Parameters:
- CNT_W, 16, width of the committed-write counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- RegWrite  input  1  write enable from the controller
- A1  input  5  read address, port 1 (instr[25:21])
- A2  input  5  read address, port 2 (instr[20:16])
- A3  input  5  write address (destination-select mux output)
- WD  input  32  write data (write-back mux output)
- PC  input  32  PC of the current instruction, trace only
- RD1  output  32  read data, port 1
- RD2  output  32  read data, port 2
- trace_valid  output  1  a write committed at the last rising edge
- trace_pc  output  32  PC of the last committed write
- trace_addr  output  5  register number of the last committed write
- trace_data  output  32  data of the last committed write
- wr_count  output  CNT_W  count of committed writes since reset

## Operation
- Storage: registers $1..$31 are 32-bit flops. $0 has no storage and always reads 0.
- Commit condition: commit = reset==1 && RegWrite==1 && A3!=0. On a rising edge with commit, regs[A3] <= WD.
- Writes to $0, and writes with RegWrite==0, change no register, trace or counter state. They only clear trace_valid.
- Read, port 1:
  - RD1 = 0 if A1==0.
  - Otherwise RD1 = WD if commit && A1==A3 (same-cycle write bypass).
  - Otherwise RD1 = regs[A1].
- Read, port 2: identical using A2.
- Bypass is purely combinational from RegWrite, A3 and WD. It is required so that a later pipelined reuse of this block has write-before-read semantics.
- Trace update on each rising edge:
  - trace_valid <= commit.
  - When commit is set, trace_pc <= PC, trace_addr <= A3 and trace_data <= WD.
  - Otherwise trace_pc, trace_addr and trace_data hold.
- Counter: wr_count <= wr_count + 1 on each commit. It wraps modulo 2^CNT_W with no saturation and no flag.
- Reset (reset==0, asynchronous, any time):
  - All registers, trace_valid, trace_pc, trace_addr, trace_data and wr_count go to 0 immediately.
  - The bypass is disabled, so RD1 and RD2 read 0 for every address while reset is low.
  - Edges while reset is low commit nothing.
- Reset release: the first rising edge with reset==1 can commit.

## Timing
- Read latency: 0 cycles. RD1 and RD2 are combinational from A1/A2, the register contents and the bypass inputs.
- Write latency: 1 edge. The value is architecturally visible from the stored array after the committing edge, and via bypass during the committing cycle.
- Trace latency: trace_* reflect the commit of the immediately preceding edge. trace_valid is a one-cycle pulse per commit.
- wr_count: updated on the same edge as the register write.
- Reset values: RD1=0, RD2=0, trace_valid=0, trace_pc=0, trace_addr=0, trace_data=0, wr_count=0, all regs 0.
- Simultaneous events:
  - A1==A2==A3 with commit: both ports return WD.
  - reset falling at the same time as a clk edge: reset wins, so no commit and state is 0.
- No handshake. The block accepts one write per cycle unconditionally.

## Test plan
- Reset: drive reset=0 mid-cycle after writing $5=0x12345678 -> RD1 (A1=5) drops to 0 without waiting for clk. trace_* are 0 and wr_count=0. After release, $5 reads 0.
- Basic write/read: RegWrite=1, A3=8, WD=0xDEADBEEF, PC=0x00003000, one edge -> RD1 (A1=8) is 0xDEADBEEF. trace_valid=1, trace_pc=0x00003000, trace_addr=8, trace_data=0xDEADBEEF, wr_count=1.
- $0 protection: RegWrite=1, A3=0, WD=0xFFFFFFFF -> RD1 (A1=0) is 0. trace_valid=0 after the edge and wr_count is unchanged.
- Bypass: regs[9]=0x1, then in the same cycle RegWrite=1, A3=9, WD=0x2, A1=9, A2=9 -> RD1=RD2=0x2 before the edge. With RegWrite=0, RD1 is 0x1.
- Ra write: A3=31 (jal destination), WD=0x0000300C -> $31 reads 0x0000300C and trace_addr=31. Then RegWrite=0 for one cycle -> trace_valid=0 while trace_data holds 0x0000300C.
- Counter wrap: with CNT_W=4, perform 17 commits to $1..$17 cycling through the addresses -> wr_count = 1 after the 17th commit. Every register holds the last value written to it.
